// File: rtl/i2c_cfg_sequencer_if.sv
// Register-write handshake between the config sequencer and the I2C engine.
// The sequencer holds req and the fields stable until the engine pulses done.
interface i2c_cfg_sequencer_if #(
    parameter int unsigned REG_ADDR_W = 16,
    parameter int unsigned DATA_W     = 8
) ();
    logic                  req;
    logic [7:0]            dev_addr;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
    logic                  done;
    logic                  ack_err;

    modport master (
        output req, dev_addr, reg_addr, data,
        input  done, ack_err
    );

    modport slave (
        input  req, dev_addr, reg_addr, data,
        output done, ack_err
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Walks an opcode-tagged configuration table (WRITE/DELAY/SKIP/END) and issues
// register writes over a req/done handshake, with NACK retry and ms delays.
module i2c_cfg_sequencer #(
    parameter int unsigned INDEX_W      = 10,
    parameter int unsigned REG_ADDR_W   = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned TICKS_PER_MS = 50000,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    output logic [INDEX_W-1:0]                 o_tbl_index,
    input  logic [2+8+REG_ADDR_W+DATA_W-1:0]   i_tbl_entry,
    i2c_cfg_sequencer_if.master                i2c,
    output logic                               o_cfg_busy,
    output logic                               o_cfg_done,
    output logic                               o_cfg_error,
    output logic [INDEX_W-1:0]                 o_err_index,
    output logic [INDEX_W-1:0]                 o_write_count
);
    localparam int unsigned ENTRY_W = 2 + 8 + REG_ADDR_W + DATA_W;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StWaitI2c, StRetryGap, StDelay, StNext, StDone, StError
    } state_e;

    typedef enum logic [1:0] {OpWrite = 2'd0, OpDelay = 2'd1, OpSkip = 2'd2, OpEnd = 2'd3} op_e;

    state_e                r_state, w_state;
    logic [INDEX_W-1:0]    r_index, w_index;
    logic [ENTRY_W-1:0]    r_entry, w_entry;
    logic                  r_req, w_req;
    logic [7:0]            r_dev, w_dev;
    logic [REG_ADDR_W-1:0] r_reg, w_reg;
    logic [DATA_W-1:0]     r_data, w_data;
    logic [RETRY_W-1:0]    r_retry, w_retry;
    logic [DATA_W-1:0]     r_ms, w_ms;
    logic [PRESC_W-1:0]    r_presc, w_presc;
    logic [INDEX_W-1:0]    r_wcount, w_wcount;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_error, w_error;
    logic [INDEX_W-1:0]    r_err_index, w_err_index;
    logic                  r_auto_pend, w_auto_pend;

    op_e                   w_op;
    logic [DATA_W-1:0]     w_entry_data;
    logic                  w_launch;

    assign w_op         = op_e'(r_entry[ENTRY_W-1 -: 2]);
    assign w_entry_data = r_entry[DATA_W-1:0];
    // r_auto_pend is only ever high on the first cycle after reset release.
    assign w_launch     = i_start || ((AUTO_START != 0) && r_auto_pend);

    always_comb begin
        w_state     = r_state;
        w_index     = r_index;
        w_entry     = r_entry;
        w_req       = r_req;
        w_dev       = r_dev;
        w_reg       = r_reg;
        w_data      = r_data;
        w_retry     = r_retry;
        w_ms        = r_ms;
        w_presc     = r_presc;
        w_wcount    = r_wcount;
        w_busy      = r_busy;
        w_done      = r_done;
        w_error     = r_error;
        w_err_index = r_err_index;
        w_auto_pend = 1'b0;

        case (r_state)
            StIdle, StDone, StError: begin
                if (w_launch) begin
                    w_index     = '0;
                    w_wcount    = '0;
                    w_done      = 1'b0;
                    w_error     = 1'b0;
                    w_err_index = '0;
                    w_retry     = '0;
                    w_busy      = 1'b1;
                    w_state     = StFetch;
                end
            end
            StFetch: begin
                w_entry = i_tbl_entry;
                w_state = StDecode;
            end
            StDecode: begin
                unique case (w_op)
                    OpWrite: begin
                        w_dev   = r_entry[ENTRY_W-3 -: 8];
                        w_reg   = r_entry[DATA_W +: REG_ADDR_W];
                        w_data  = w_entry_data;
                        w_req   = 1'b1;
                        w_state = StWaitI2c;
                    end
                    OpDelay: begin
                        w_ms    = w_entry_data;
                        w_presc = '0;
                        w_state = (w_entry_data == '0) ? StNext : StDelay;
                    end
                    OpSkip: w_state = StNext;
                    OpEnd: begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = StDone;
                    end
                endcase
            end
            StWaitI2c: begin
                if (i2c.done) begin
                    w_req = 1'b0;
                    if (!i2c.ack_err) begin
                        if (r_wcount != '1) begin
                            w_wcount = r_wcount + 1'b1;
                        end
                        w_state = StNext;
                    end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
                        w_retry = r_retry + 1'b1;
                        w_state = StRetryGap;
                    end else begin
                        w_err_index = r_index;
                        w_error     = 1'b1;
                        w_busy      = 1'b0;
                        w_state     = StError;
                    end
                end
            end
            StRetryGap: begin
                w_req   = 1'b1;
                w_state = StWaitI2c;
            end
            StDelay: begin
                if (r_presc == PRESC_W'(TICKS_PER_MS - 1)) begin
                    w_presc = '0;
                    w_ms    = r_ms - 1'b1;
                    if (r_ms == DATA_W'(1)) begin
                        w_state = StNext;
                    end
                end else begin
                    w_presc = r_presc + 1'b1;
                end
            end
            StNext: begin
                w_retry = '0;
                if (r_index == '1) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = StDone;
                end else begin
                    w_index = r_index + 1'b1;
                    w_state = StFetch;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_index     <= '0;
            r_entry     <= '0;
            r_req       <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_data      <= '0;
            r_retry     <= '0;
            r_ms        <= '0;
            r_presc     <= '0;
            r_wcount    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_auto_pend <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_index     <= w_index;
            r_entry     <= w_entry;
            r_req       <= w_req;
            r_dev       <= w_dev;
            r_reg       <= w_reg;
            r_data      <= w_data;
            r_retry     <= w_retry;
            r_ms        <= w_ms;
            r_presc     <= w_presc;
            r_wcount    <= w_wcount;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
            r_err_index <= w_err_index;
            r_auto_pend <= w_auto_pend;
        end
    end

    assign o_tbl_index   = r_index;
    assign i2c.req       = r_req;
    assign i2c.dev_addr  = r_dev;
    assign i2c.reg_addr  = r_reg;
    assign i2c.data      = r_data;
    assign o_cfg_busy    = r_busy;
    assign o_cfg_done    = r_done;
    assign o_cfg_error   = r_error;
    assign o_err_index   = r_err_index;
    assign o_write_count = r_wcount;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench: an 8-entry table ROM model and a fixed-latency I2C master
// that can NACK a chosen index a set number of times.
module tb_i2c_cfg_sequencer;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  tbl_index;
    logic [33:0] tbl_entry;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [2:0]  err_index, write_count;

    logic [33:0] tbl [8];
    assign tbl_entry = tbl[tbl_index];

    i2c_cfg_sequencer_if #(.REG_ADDR_W(16), .DATA_W(8)) bus ();

    i2c_cfg_sequencer #(
        .INDEX_W(3), .REG_ADDR_W(16), .DATA_W(8),
        .MAX_RETRY(3), .TICKS_PER_MS(10), .AUTO_START(1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_tbl_index   (tbl_index),
        .i_tbl_entry   (tbl_entry),
        .i2c           (bus),
        .o_cfg_busy    (cfg_busy),
        .o_cfg_done    (cfg_done),
        .o_cfg_error   (cfg_error),
        .o_err_index   (err_index),
        .o_write_count (write_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: request log plus NACK injection on index nack_idx.
    int          n_req = 0;
    logic [31:0] log_fld [64];
    int          log_idx [64];
    int          log_cyc [64];
    int          done_cyc [64];
    int          nack_idx = -1;
    int          nack_n = 0;
    int          lat = 0;
    int          attempt = 0;
    int          last_idx = -1;
    bit          last_nack = 1'b0;
    bit          prev_req = 1'b0;

    always @(negedge clk) begin
        bit nack;
        bus.done    = 1'b0;
        bus.ack_err = 1'b0;
        if (bus.req === 1'b1) begin
            if (!prev_req) begin
                if (n_req < 64) begin
                    log_fld[n_req] = {bus.dev_addr, bus.reg_addr, bus.data};
                    log_idx[n_req] = int'(tbl_index);
                    log_cyc[n_req] = cyc;
                end
                attempt  = (last_idx == int'(tbl_index) && last_nack) ? attempt + 1 : 1;
                last_idx = int'(tbl_index);
                n_req++;
                lat = 0;
            end
            lat++;
            if (lat == LAT) begin
                nack        = (int'(tbl_index) == nack_idx) && (attempt <= nack_n);
                bus.done    = 1'b1;
                bus.ack_err = nack;
                last_nack   = nack;
                if (n_req <= 64) done_cyc[n_req-1] = cyc;
            end
        end
        prev_req = (bus.req === 1'b1);
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [1:0] op, input logic [7:0] dev,
                                       input logic [15:0] ra, input logic [7:0] d);
        return {op, dev, ra, d};
    endfunction

    task automatic fill_end();
        for (int i = 0; i < 8; i++) tbl[i] = mk(2'd3, 8'h00, 16'h0000, 8'h00);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_end(input string tag);
        bit fin = 1'b0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(negedge clk);
            if (!cfg_busy && (cfg_done || cfg_error)) fin = 1'b1;
        end
        check_eq({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  gap;
        bit  found;

        fill_end();
        tbl[0] = mk(2'd0, 8'h78, 16'h3103, 8'h11);
        tbl[1] = mk(2'd0, 8'h78, 16'h3008, 8'h82);

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_done", 32'(cfg_done), 32'd0);
        check_eq("rst_req", 32'(bus.req), 32'd0);
        check_eq("rst_index", 32'(tbl_index), 32'd0);
        check_eq("rst_wcount", 32'(write_count), 32'd0);

        // Two writes then END, launched by AUTO_START.
        base = n_req;
        rst = 1'b0;
        run_to_end("t1");
        check_eq("t1_nreq", 32'(n_req - base), 32'd2);
        check_eq("t1_fld0", log_fld[base], 32'h7831_0311);
        check_eq("t1_fld1", log_fld[base+1], 32'h7830_0882);
        check_eq("t1_w2w_gap", 32'(log_cyc[base+1] - done_cyc[base]), 32'd4);
        check_eq("t1_wcount", 32'(write_count), 32'd2);
        check_eq("t1_done", 32'(cfg_done), 32'd1);
        check_eq("t1_index", 32'(tbl_index), 32'd2);

        // DELAY 3 ms and DELAY 0 between writes; a start while busy is ignored.
        fill_end();
        tbl[0] = mk(2'd0, 8'h50, 16'h0001, 8'hAA);
        tbl[1] = mk(2'd1, 8'h00, 16'h0000, 8'd3);
        tbl[2] = mk(2'd1, 8'h00, 16'h0000, 8'd0);
        tbl[3] = mk(2'd0, 8'h50, 16'h0002, 8'hBB);
        base = n_req;
        pulse_start();
        check_eq("t2_busy_after_start", 32'(cfg_busy), 32'd1);
        check_eq("t2_done_cleared", 32'(cfg_done), 32'd0);
        repeat (20) @(negedge clk);
        pulse_start();
        run_to_end("t2");
        check_eq("t2_nreq", 32'(n_req - base), 32'd2);
        gap = log_cyc[base+1] - done_cyc[base];
        // 4 write overhead + 3 per delay entry x2 + 30 tick cycles
        check_eq("t2_delay_gap", 32'(gap >= 39 && gap <= 41), 32'd1);
        check_eq("t2_fld1", log_fld[base+1], 32'h5000_02BB);
        check_eq("t2_wcount", 32'(write_count), 32'd2);
        check_eq("t2_index", 32'(tbl_index), 32'd4);

        // SKIP entry at index 1 never reaches the bus.
        fill_end();
        tbl[0] = mk(2'd0, 8'h12, 16'h0010, 8'h01);
        tbl[1] = mk(2'd2, 8'hFF, 16'hFFFF, 8'hFF);
        tbl[2] = mk(2'd0, 8'h12, 16'h0011, 8'h02);
        base = n_req;
        pulse_start();
        run_to_end("t3");
        check_eq("t3_nreq", 32'(n_req - base), 32'd2);
        check_eq("t3_idx1", 32'(log_idx[base+1]), 32'd2);
        check_eq("t3_wcount", 32'(write_count), 32'd2);

        // Index 4 NACKed twice then acked: three identical requests.
        fill_end();
        for (int i = 0; i < 4; i++) tbl[i] = mk(2'd0, 8'h34, 16'(i), 8'(i));
        tbl[4] = mk(2'd0, 8'h34, 16'h0444, 8'h44);
        nack_idx = 4;
        nack_n = 2;
        base = n_req;
        pulse_start();
        run_to_end("t4");
        check_eq("t4_nreq", 32'(n_req - base), 32'd7);
        check_eq("t4_retry_fld1", log_fld[base+5], 32'h3404_4444);
        check_eq("t4_retry_fld2", log_fld[base+6], 32'h3404_4444);
        check_eq("t4_retry_idx", 32'(log_idx[base+6]), 32'd4);
        check_eq("t4_retry_gap", 32'(log_cyc[base+5] - done_cyc[base+4]), 32'd2);
        check_eq("t4_error", 32'(cfg_error), 32'd0);
        check_eq("t4_wcount", 32'(write_count), 32'd5);

        // Four NACKs exhaust the retries.
        nack_n = 4;
        base = n_req;
        pulse_start();
        run_to_end("t4b");
        check_eq("t4b_error", 32'(cfg_error), 32'd1);
        check_eq("t4b_done", 32'(cfg_done), 32'd0);
        check_eq("t4b_err_index", 32'(err_index), 32'd4);
        check_eq("t4b_wcount", 32'(write_count), 32'd4);
        repeat (20) @(negedge clk);
        check_eq("t4b_nreq", 32'(n_req - base), 32'd8);
        nack_n = 0;

        // No END: all 8 entries written, stop at index 7, count saturates.
        for (int i = 0; i < 8; i++) tbl[i] = mk(2'd0, 8'h20, 16'h0100 + 16'(i), 8'(i));
        base = n_req;
        pulse_start();
        check_eq("t5_error_cleared", 32'(cfg_error), 32'd0);
        run_to_end("t5");
        check_eq("t5_nreq", 32'(n_req - base), 32'd8);
        check_eq("t5_last_idx", 32'(log_idx[base+7]), 32'd7);
        check_eq("t5_index", 32'(tbl_index), 32'd7);
        check_eq("t5_wcount_sat", 32'(write_count), 32'd7);
        check_eq("t5_done", 32'(cfg_done), 32'd1);

        // Reset during the index-2 write, then AUTO_START reruns from 0.
        fill_end();
        for (int i = 0; i < 4; i++) tbl[i] = mk(2'd0, 8'h66, 16'h0200 + 16'(i), 8'h5A);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            if (bus.req === 1'b1 && tbl_index == 3'd2) found = 1'b1;
        end
        check_eq("t6_reached_idx2", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_req", 32'(bus.req), 32'd0);
        check_eq("t6_rst_busy", 32'(cfg_busy), 32'd0);
        check_eq("t6_rst_index", 32'(tbl_index), 32'd0);
        check_eq("t6_rst_wcount", 32'(write_count), 32'd0);
        @(negedge clk);
        base = n_req;
        rst = 1'b0;
        run_to_end("t6");
        check_eq("t6_nreq", 32'(n_req - base), 32'd4);
        check_eq("t6_first_idx", 32'(log_idx[base]), 32'd0);
        check_eq("t6_wcount", 32'(write_count), 32'd4);
        check_eq("t6_done", 32'(cfg_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
